// File: rtl/uart_rx_majority.sv
// rtl/uart_rx_majority.sv - UART 8N1 receiver with 3-sample majority vote, framing error and break detection
module uart_rx_majority #(
  parameter int CLOCKS_PER_BAUD = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_error,
  output logic       break_detect,
  output logic       busy
);

  localparam int CW   = $clog2(CLOCKS_PER_BAUD);
  localparam int HALF = CLOCKS_PER_BAUD / 2;

  localparam logic [CW-1:0] C_HM1  = CW'(HALF - 1);
  localparam logic [CW-1:0] C_H    = CW'(HALF);
  localparam logic [CW-1:0] C_HP1  = CW'(HALF + 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLOCKS_PER_BAUD - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t        state;
  logic          sync1;
  logic          sync2;
  logic          prev;
  logic [1:0]    settle;
  logic          armed;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          smp0;
  logic          smp1;

  logic rx_s;
  logic fall;
  logic vote;

  assign rx_s = sync2;
  // A falling edge only counts once the line has really been seen high after reset,
  // so a line that is already low at release cannot start a frame.
  assign fall = armed & prev & ~rx_s;
  // Third sample is the live synchronised line at cnt = HALF+1.
  assign vote = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);

  // Two-flop synchroniser, edge-detect register and post-reset arming of edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      prev   <= 1'b1;
      settle <= 2'd0;
      armed  <= 1'b0;
    end else begin
      sync1 <= uart_rx;
      sync2 <= sync1;
      prev  <= sync2;
      if (settle != 2'd3) begin
        settle <= settle + 2'd1;
      end
      armed <= armed | ((settle == 2'd3) & rx_s);
    end
  end

  // Frame FSM: bit timing, majority sampling, shift register and registered result strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= 3'd0;
      shreg        <= 8'h00;
      smp0         <= 1'b1;
      smp1         <= 1'b1;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      frame_error  <= 1'b0;
      break_detect <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;

      if (state == START || state == DATA || state == STOP) begin
        cnt <= (cnt == C_LAST) ? '0 : cnt + CW'(1);
        if (cnt == C_HM1) begin
          smp0 <= rx_s;
        end
        if (cnt == C_H) begin
          smp1 <= rx_s;
        end
      end

      case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == C_HP1 && vote) begin
            state <= IDLE;
          end else if (cnt == C_LAST) begin
            state   <= DATA;
            bit_idx <= 3'd0;
          end
        end
        DATA: begin
          if (cnt == C_HP1) begin
            shreg <= {vote, shreg[7:1]};
          end
          if (cnt == C_LAST) begin
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        STOP: begin
          // Decide at the stop-bit centre and leave at once so a back-to-back start edge is not missed.
          if (cnt == C_HP1) begin
            if (vote) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              state    <= IDLE;
            end else begin
              frame_error <= 1'b1;
              if (shreg == 8'h00) begin
                break_detect <= 1'b1;
                state        <= BREAK;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        BREAK: begin
          if (rx_s) begin
            break_detect <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Busy flag registered from the current state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
    end else begin
      busy <= (state != IDLE);
    end
  end

endmodule
